aud_mode_ctrl: RTL

Top-level sequencer for the audio recorder/player path. It turns debounced key pulses into start/pause/stop pulses for the I2S recorder (AudRecorder) and the playback DSP. It owns the single SRAM port and multiplexes it between recorder writes and DSP reads. It also records the end address of the last take so playback stops, or loops, at the right point.

---
 rtl/aud_pkg.sv | 48 ++++
 rtl/aud_sram_mux.sv | 39 +++
 rtl/aud_mode_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/aud_pkg.sv
// Shared types and constants for the audio record/play sequencer.
// Build option AUD_CTRL_LOOP_PLAY_EN adds the S_RESTART loop state.
package aud_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;

  // bit positions in the prioritised key vector
  localparam int KEY_PLAY = 0;
  localparam int KEY_REC  = 1;
  localparam int KEY_STOP = 2;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REC        = 3'd1,
    S_REC_PAUSE  = 3'd2,
    S_PLAY       = 3'd3,
    S_PLAY_PAUSE = 3'd4
`ifdef AUD_CTRL_LOOP_PLAY_EN
    ,
    S_RESTART    = 3'd5
`endif
  } aud_state_e;

  typedef struct packed {
    logic rec_start;
    logic rec_pause;
    logic rec_stop;
    logic dsp_start;
    logic dsp_pause;
    logic dsp_stop;
  } aud_ctl_t;

  // stop > rec > play; result is one-hot or zero
  function automatic logic [2:0] key_pri(
    input logic stop,
    input logic rec,
    input logic play
  );
    logic [2:0] k;
    k = 3'b000;
    if (stop)      k[KEY_STOP] = 1'b1;
    else if (rec)  k[KEY_REC]  = 1'b1;
    else if (play) k[KEY_PLAY] = 1'b1;
    return k;
  endfunction

endpackage

// File: rtl/aud_sram_mux.sv
// Registered SRAM port mux: recorder writes when rec_owner, else DSP reads.
// Ports: clk/rst, rec_owner, rec wr/addr/data, dsp rd/addr, sram addr/we/wdata.
module aud_sram_mux
  import aud_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rec_owner,
  input  logic              rec_wr,
  input  logic [ADDR_W-1:0] rec_addr,
  input  logic [DATA_W-1:0] rec_data,
  input  logic              dsp_rd,
  input  logic [ADDR_W-1:0] dsp_addr,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic [DATA_W-1:0] sram_wdata
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr  <= '0;
      sram_we    <= 1'b0;
      sram_wdata <= '0;
    end else if (rec_owner) begin
      sram_we <= rec_wr;
      if (rec_wr) begin
        sram_addr  <= rec_addr;
        sram_wdata <= rec_data;
      end
    end else begin
      sram_we <= 1'b0;
      if (dsp_rd) sram_addr <= dsp_addr;
    end
  end

endmodule

// File: rtl/aud_mode_ctrl.sv
// Record/play sequencer: key pulses to recorder/DSP pulses, SRAM mux, take end.
// Build option AUD_CTRL_LOOP_PLAY_EN: loop playback via S_RESTART.
module aud_mode_ctrl
  import aud_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter int              DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_stop,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  input  logic              i_rec_wr,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_data,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  input  logic              i_dsp_rd,
  input  logic [ADDR_W-1:0] i_dsp_addr,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic [2:0]        o_state,
  output logic              o_full
);

  aud_state_e state_q, state_d;
  aud_ctl_t   ctl_q, ctl_d;
  logic       end_valid_q;
  logic       clr_take;
  logic       rec_owner;
  logic       wr_full;
  logic       take_end;
  logic [2:0] keys;

  assign keys      = key_pri(i_key_stop, i_key_rec, i_key_play);
  assign rec_owner = (state_q == S_REC) || (state_q == S_REC_PAUSE);
  assign wr_full   = rec_owner && i_rec_wr && (i_rec_addr == MAX_ADDR);
  assign take_end  = i_dsp_rd && (i_dsp_addr == o_end_addr);

  always_comb begin
    state_d  = state_q;
    ctl_d    = '0;
    clr_take = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          keys[KEY_STOP]: ;
          keys[KEY_REC]: begin
            ctl_d.rec_start = 1'b1;
            clr_take        = 1'b1;
            state_d         = S_REC;
          end
          keys[KEY_PLAY]: begin
            if (end_valid_q) begin
              ctl_d.dsp_start = 1'b1;
              state_d         = S_PLAY;
            end
          end
          default: ;
        endcase
      end
      S_REC: begin
        if (keys[KEY_STOP] || wr_full) begin
          ctl_d.rec_stop = 1'b1;
          state_d        = S_IDLE;
        end else if (keys[KEY_REC]) begin
          ctl_d.rec_pause = 1'b1;
          state_d         = S_REC_PAUSE;
        end
      end
      S_REC_PAUSE: begin
        if (keys[KEY_STOP] || wr_full) begin
          ctl_d.rec_stop = 1'b1;
          state_d        = S_IDLE;
        end else if (keys[KEY_REC]) begin
          ctl_d.rec_start = 1'b1;
          state_d         = S_REC;
        end
      end
      S_PLAY: begin
        if (keys[KEY_STOP]) begin
          ctl_d.dsp_stop = 1'b1;
          state_d        = S_IDLE;
        end else if (take_end) begin
          ctl_d.dsp_stop = 1'b1;
`ifdef AUD_CTRL_LOOP_PLAY_EN
          state_d        = S_RESTART;
`else
          state_d        = S_IDLE;
`endif
        end else if (keys[KEY_PLAY]) begin
          ctl_d.dsp_pause = 1'b1;
          state_d         = S_PLAY_PAUSE;
        end
      end
      S_PLAY_PAUSE: begin
        if (keys[KEY_STOP]) begin
          ctl_d.dsp_stop = 1'b1;
          state_d        = S_IDLE;
        end else if (keys[KEY_PLAY]) begin
          ctl_d.dsp_start = 1'b1;
          state_d         = S_PLAY;
        end
      end
`ifdef AUD_CTRL_LOOP_PLAY_EN
      S_RESTART: begin
        // DSP already stopped on entry; a stop key just abandons the loop
        if (keys[KEY_STOP]) begin
          state_d = S_IDLE;
        end else begin
          ctl_d.dsp_start = 1'b1;
          state_d         = S_PLAY;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_end_addr  <= '0;
      end_valid_q <= 1'b0;
      o_full      <= 1'b0;
    end else if (clr_take) begin
      o_end_addr  <= '0;
      end_valid_q <= 1'b0;
      o_full      <= 1'b0;
    end else if (rec_owner && i_rec_wr) begin
      o_end_addr  <= i_rec_addr;
      end_valid_q <= 1'b1;
      if (wr_full) o_full <= 1'b1;
    end
  end

  assign o_rec_start = ctl_q.rec_start;
  assign o_rec_pause = ctl_q.rec_pause;
  assign o_rec_stop  = ctl_q.rec_stop;
  assign o_dsp_start = ctl_q.dsp_start;
  assign o_dsp_pause = ctl_q.dsp_pause;
  assign o_dsp_stop  = ctl_q.dsp_stop;
  assign o_state     = state_q;

  aud_sram_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .clk       (i_clk),
    .rst       (i_rst),
    .rec_owner (rec_owner),
    .rec_wr    (i_rec_wr),
    .rec_addr  (i_rec_addr),
    .rec_data  (i_rec_data),
    .dsp_rd    (i_dsp_rd),
    .dsp_addr  (i_dsp_addr),
    .sram_addr (o_sram_addr),
    .sram_we   (o_sram_we),
    .sram_wdata(o_sram_wdata)
  );

endmodule
